// File: rtl/bus_datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: opcodes, sequencer states, index width.
package bus_datapath_pkg;

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpAnd  = 4'd2,
      OpOr   = 4'd3,
      OpShl  = 4'd4,
      OpShr  = 4'd5,
      OpShra = 4'd6,
      OpRol  = 4'd7,
      OpRor  = 4'd8,
      OpNeg  = 4'd9,
      OpNot  = 4'd10,
      OpMul  = 4'd11,
      OpDiv  = 4'd12
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StLoadY,
      StExec,
      StDivWait,
      StWb,
      StWbHi
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring signed divider: magnitudes are divided, signs are fixed up on the outputs.
module seq_divider
   import bus_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             rdy
);

   localparam int unsigned CntW = clog2(WIDTH);

   logic             active_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
   logic             neg_quo_q, by_zero_q;

   logic [WIDTH-1:0] dvd_abs, dvs_abs, r_in, q_in, d_in, r_nx, q_nx;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH+1:0] trial;

   assign dvd_abs = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
   assign dvs_abs = divisor[WIDTH-1] ? ('0 - divisor) : divisor;

   // The go cycle already performs the first step so rdy lands exactly WIDTH cycles later.
   always_comb begin
      r_in = go ? '0 : rem_q;
      q_in = go ? dvd_abs : quo_q;
      d_in = go ? dvs_abs : dvs_q;
      r_sh = {r_in, q_in[WIDTH-1]};
      trial = {1'b0, r_sh} - {2'b00, d_in};
      if (!trial[WIDTH+1]) begin
         r_nx = trial[WIDTH-1:0];
         q_nx = {q_in[WIDTH-2:0], 1'b1};
      end else begin
         r_nx = r_sh[WIDTH-1:0];
         q_nx = {q_in[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         active_q  <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         neg_quo_q <= 1'b0;
         by_zero_q <= 1'b0;
      end else if (go) begin
         active_q  <= 1'b1;
         cnt_q     <= CntW'(WIDTH - 1);
         rem_q     <= r_nx;
         quo_q     <= q_nx;
         dvs_q     <= dvs_abs;
         dvd_q     <= dividend;
         neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         by_zero_q <= (divisor == '0);
      end else if (active_q) begin
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            rem_q <= r_nx;
            quo_q <= q_nx;
         end else begin
            active_q <= 1'b0;
         end
      end
   end

   assign rdy = active_q && (cnt_q == '0);

   always_comb begin
      if (by_zero_q) begin
         quotient  = '1;
         remainder = dvd_q;
      end else begin
         quotient  = neg_quo_q ? ('0 - quo_q) : quo_q;
         remainder = dvd_q[WIDTH-1] ? ('0 - rem_q) : rem_q;
      end
   end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath with an internal T-state sequencer, one instruction per start.
module bus_datapath_seq
   import bus_datapath_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NREGS   = 16,
   parameter bit          R0_ZERO = 1'b1,
   localparam int unsigned IdxW   = clog2(NREGS)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [IdxW-1:0]  rs,
   input  logic [IdxW-1:0]  rt,
   input  logic [IdxW-1:0]  rd,
   input  logic             load_en,
   input  logic [IdxW-1:0]  load_idx,
   input  logic [WIDTH-1:0] load_data,
   input  logic [IdxW-1:0]  dbg_idx,
   output logic [WIDTH-1:0] dbg_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] bus_out
);

   localparam int unsigned ShW = clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   regs_q [NREGS];
   logic [3:0]         op_q;
   logic [IdxW-1:0]    rs_q, rt_q, rd_q;
   logic [WIDTH-1:0]   y_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] z_q;
   logic               div_zero_q;

   logic [WIDTH-1:0]   bus, rs_val, rt_val, alu_lo, alu_hi, div_quo, div_rem;
   logic [2*WIDTH-1:0] rot_l, rot_r;
   logic signed [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [ShW-1:0]     sh;
   logic               div_go, div_rdy, is_muldiv, is_legal;

   assign rs_val = (R0_ZERO && rs_q == '0) ? '0 : regs_q[rs_q];
   assign rt_val = (R0_ZERO && rt_q == '0) ? '0 : regs_q[rt_q];
   assign dbg_data = (R0_ZERO && dbg_idx == '0) ? '0 : regs_q[dbg_idx];

   assign is_muldiv = (op_q == OpMul) || (op_q == OpDiv);
   assign is_legal  = (op_q <= OpDiv);

   always_comb begin
      bus = '0;
      case (state_q)
         StLoadY: bus = rs_val;
         StExec:  bus = rt_val;
         StWb:    bus = z_q[WIDTH-1:0];
         StWbHi:  bus = z_q[2*WIDTH-1:WIDTH];
         default: ;
      endcase
   end

   assign sh    = bus[ShW-1:0];
   assign mul_a = {{WIDTH{y_q[WIDTH-1]}}, y_q};
   assign mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};
   assign prod  = mul_a * mul_b;
   assign rot_l = {y_q, y_q} << sh;
   assign rot_r = {y_q, y_q} >> sh;

   // Illegal opcodes fall to the default and leave Z at zero; write-back is suppressed later.
   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      case (op_q)
         OpAdd:  alu_lo = y_q + bus;
         OpSub:  alu_lo = y_q - bus;
         OpAnd:  alu_lo = y_q & bus;
         OpOr:   alu_lo = y_q | bus;
         OpShl:  alu_lo = y_q << sh;
         OpShr:  alu_lo = y_q >> sh;
         OpShra: alu_lo = $signed(y_q) >>> sh;
         OpRol:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
         OpRor:  alu_lo = rot_r[WIDTH-1:0];
         OpNeg:  alu_lo = '0 - bus;
         OpNot:  alu_lo = ~bus;
         OpMul:  {alu_hi, alu_lo} = prod;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      div_go  = 1'b0;
      case (state_q)
         StIdle:    if (start) state_d = StLoadY;
         StLoadY:   state_d = StExec;
         StExec: begin
            if (op_q == OpDiv) begin
               div_go  = 1'b1;
               state_d = StDivWait;
            end else begin
               state_d = StWb;
            end
         end
         StDivWait: if (div_rdy) state_d = StWb;
         StWb:      state_d = is_muldiv ? StWbHi : StIdle;
         StWbHi:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
         op_q       <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         y_q        <= '0;
         z_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (load_en && !(R0_ZERO && load_idx == '0)) regs_q[load_idx] <= load_data;
               if (start) begin
                  op_q       <= op;
                  rs_q       <= rs;
                  rt_q       <= rt;
                  rd_q       <= rd;
                  div_zero_q <= 1'b0;
               end
            end
            StLoadY: y_q <= bus;
            StExec: begin
               if (op_q != OpDiv) z_q <= {alu_hi, alu_lo};
               else if (bus == '0) div_zero_q <= 1'b1;
            end
            StDivWait: if (div_rdy) z_q <= {div_rem, div_quo};
            StWb: begin
               if (is_muldiv) lo_q <= z_q[WIDTH-1:0];
               else if (is_legal && !(R0_ZERO && rd_q == '0)) regs_q[rd_q] <= bus;
            end
            StWbHi: hi_q <= z_q[2*WIDTH-1:WIDTH];
            default: ;
         endcase
      end
   end

   seq_divider #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk       (clk),
      .clr       (clr),
      .go        (div_go),
      .dividend  (y_q),
      .divisor   (bus),
      .quotient  (div_quo),
      .remainder (div_rem),
      .rdy       (div_rdy)
   );

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StWb && !is_muldiv) || (state_q == StWbHi);
   assign div_zero = div_zero_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign bus_out  = bus;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq; a second instance with R0 as an ordinary register.
module tb_bus_datapath_seq;
   import bus_datapath_pkg::*;

   logic        clk = 1'b0;
   logic        clr, start, load_en;
   logic [3:0]  op, rs, rt, rd, load_idx, dbg_idx;
   logic [31:0] load_data;

   logic [31:0] dbg_data, hi_out, lo_out, bus_out;
   logic        busy, done, div_zero;
   logic [31:0] dbg_data0, hi_out0, lo_out0, bus_out0;
   logic        busy0, done0, div_zero0;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      int          kind;  // 0 reg, 1 lo, 2 hi, 3 div_zero, 4 reg of R0-ordinary instance
      int          idx;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .rs(rs), .rt(rt), .rd(rd),
      .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data), .busy(busy), .done(done),
      .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out), .bus_out(bus_out)
   );

   bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b0)) dut0 (
      .clk(clk), .clr(clr), .start(start), .op(op), .rs(rs), .rt(rt), .rd(rd),
      .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data0), .busy(busy0), .done(done0),
      .div_zero(div_zero0), .hi_out(hi_out0), .lo_out(lo_out0), .bus_out(bus_out0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int kind, input int idx, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.kind = kind; e.idx = idx; e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         dbg_idx = 4'(e.idx);
         #1;
         case (e.kind)
            0:       chk(e.tag, 64'(dbg_data), 64'(e.val));
            1:       chk(e.tag, 64'(lo_out), 64'(e.val));
            2:       chk(e.tag, 64'(hi_out), 64'(e.val));
            3:       chk(e.tag, 64'(div_zero), 64'(e.val));
            default: chk(e.tag, 64'(dbg_data0), 64'(e.val));
         endcase
      end
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      @(negedge clk);
      load_en = 1'b1; load_idx = 4'(idx); load_data = d;
      @(posedge clk);
      #1 load_en = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] o, input int s, input int t,
                         input int d, input int exp_cyc, input bit pulse_mid);
      int cyc, busy_low, extra;
      bit got;
      @(negedge clk);
      op = o; rs = 4'(s); rt = 4'(t); rd = 4'(d); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1; got = 1'b0; busy_low = 0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         start = pulse_mid && (cyc == 2);
         if (!busy) busy_low++;
         if (done) got = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      chk({tag, " done_seen"}, 64'(got), 64'(1));
      chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, " busy_until_done"}, 64'(busy_low), 64'(0));
      @(negedge clk);
      chk({tag, " idle_after"}, 64'(busy), 64'(0));
      extra = done ? 1 : 0;
      repeat (4) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk({tag, " single_done"}, 64'(extra), 64'(0));
      drain();
   endtask

   initial begin
      int early_done, late_done;
      clr = 1'b1; start = 1'b0; load_en = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
      load_idx = '0; load_data = '0; dbg_idx = '0;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst done", 64'(done), 64'(0));
      chk("rst bus", 64'(bus_out), 64'(0));
      push("rst r2", 0, 2, 32'h0); push("rst lo", 1, 0, 32'h0);
      push("rst hi", 2, 0, 32'h0); push("rst dz", 3, 0, 32'h0);
      drain();

      load(2, 32'h0000_0025); load(3, 32'h0000_0011);
      push("add r1", 0, 1, 32'h0000_0036);
      run_op("add", OpAdd, 2, 3, 1, 3, 1'b0);

      load(2, 32'hFFFF_FFFA); load(3, 32'h0000_0004);
      push("mul lo", 1, 0, 32'hFFFF_FFE8); push("mul hi", 2, 0, 32'hFFFF_FFFF);
      run_op("mul", OpMul, 2, 3, 0, 4, 1'b0);
      push("div lo", 1, 0, 32'hFFFF_FFFF); push("div hi", 2, 0, 32'hFFFF_FFFE);
      push("div dz", 3, 0, 32'h0);
      run_op("div", OpDiv, 2, 3, 0, 36, 1'b0);

      load(2, 32'h0000_0007); load(3, 32'h0000_0000);
      push("div0 lo", 1, 0, 32'hFFFF_FFFF); push("div0 hi", 2, 0, 32'h0000_0007);
      push("div0 dz", 3, 0, 32'h1);
      run_op("div0", OpDiv, 2, 3, 0, 36, 1'b0);
      load(2, 32'h0000_0001); load(3, 32'h0000_0002);
      push("add2 r1", 0, 1, 32'h0000_0003); push("add2 dz_clear", 3, 0, 32'h0);
      run_op("add2", OpAdd, 2, 3, 1, 3, 1'b0);

      load(0, 32'h0000_0055);
      push("r0z r5", 0, 5, 32'h0); push("r0z dbg0", 0, 0, 32'h0);
      push("r0n r5", 4, 5, 32'h0000_00AA); push("r0n dbg0", 4, 0, 32'h0000_0055);
      run_op("r0", OpAdd, 0, 0, 5, 3, 1'b0);

      load(2, 32'h8000_0000); load(3, 32'h0000_0004);
      push("shra r6", 0, 6, 32'hF800_0000);
      run_op("shra", OpShra, 2, 3, 6, 3, 1'b1);
      load(2, 32'h8000_0001);
      push("rol4 r7", 0, 7, 32'h0000_0018);
      run_op("rol4", OpRol, 2, 3, 7, 3, 1'b0);
      load(3, 32'h0000_0024);
      push("rol36 r8", 0, 8, 32'h0000_0018);
      run_op("rol36", OpRol, 2, 3, 8, 3, 1'b0);

      load(2, 32'h8000_0000); load(3, 32'hFFFF_FFFF);
      push("ovf lo", 1, 0, 32'h8000_0000); push("ovf hi", 2, 0, 32'h0);
      run_op("ovf", OpDiv, 2, 3, 0, 36, 1'b0);
      load(2, 32'hFFFF_FFF9); load(3, 32'h0000_0002);
      push("neg7 lo", 1, 0, 32'hFFFF_FFFD); push("neg7 hi", 2, 0, 32'hFFFF_FFFF);
      run_op("neg7", OpDiv, 2, 3, 0, 36, 1'b0);

      push("ill r1", 0, 1, 32'h0000_0003);
      run_op("ill", 4'd13, 2, 3, 1, 3, 1'b0);

      load(2, 32'h0000_0007); load(3, 32'h0000_0002);
      @(negedge clk);
      op = OpDiv; rs = 4'd2; rt = 4'd3; rd = 4'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      early_done = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done) early_done++;
         if (c == 10) clr = 1'b1;
         else @(posedge clk);
      end
      @(posedge clk);
      #1 clr = 1'b0;
      chk("clr early_done", 64'(early_done), 64'(0));
      @(negedge clk);
      chk("clr busy", 64'(busy), 64'(0));
      late_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) late_done++;
      end
      chk("clr no_done", 64'(late_done), 64'(0));
      for (int i = 0; i < 16; i++) push("clr reg", 0, i, 32'h0);
      push("clr lo", 1, 0, 32'h0); push("clr hi", 2, 0, 32'h0);
      drain();
      load(2, 32'h0000_0005); load(3, 32'h0000_0006);
      push("post r1", 0, 1, 32'h0000_000B);
      run_op("post", OpAdd, 2, 3, 1, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
